// File: rtl/alu_control_if.sv
// alu_control_if: decode request (alu_op, funct3, funct7b5) and registered
// decode result (alu_ctrl, illegal) between the main decoder and ALU select.
// master = side that issues instruction fields, slave = alu_control.
interface alu_control_if #(
  parameter int CTRL_W = 4
);

  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;

  modport master (
    output alu_op,
    output funct3,
    output funct7b5,
    input  alu_ctrl,
    input  illegal
  );

  modport slave (
    input  alu_op,
    input  funct3,
    input  funct7b5,
    output alu_ctrl,
    output illegal
  );

endinterface

// File: rtl/alu_control.sv
// alu_control: RV32I ALU control decoder for the SEQ datapath.
// Maps alu_op + funct3 + funct7b5 to a 4-bit ALU operation code, with one
// register stage between decode and the ALU select.
// Optional feature macro: ALU_CTRL_EXT_OPS_EN
//   defined   -> XOR, SLL, SRL, SRA, SLT, SLTU are decoded
//   undefined -> only ADD/SUB/AND/OR; other R/I funct3 flag illegal
module alu_control #(
  parameter int CTRL_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_control_if.slave bus
);

  // ALU operation encoding
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1001);

  // Main-decoder alu_op classes
  localparam logic [1:0] ALUOP_ADDR   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } dec_t;

  localparam dec_t DEC_ILLEGAL = '{ctrl: OP_ADD, illegal: 1'b1};

  // Decode of the arithmetic/logic class (alu_op = 1x).
  // is_itype forces funct3=000 to ADD since I-type has no SUBI; bit 30 of an
  // I-type immediate is still meaningful for SRLI/SRAI.
  function automatic dec_t decode_alu(input logic       is_itype,
                                      input logic [2:0] f3,
                                      input logic       f7b5);
    dec_t d;
    d = '{ctrl: OP_ADD, illegal: 1'b0};
    case (f3)
      3'b000:  d.ctrl = (f7b5 && !is_itype) ? OP_SUB : OP_ADD;
      3'b111:  d.ctrl = OP_AND;
      3'b110:  d.ctrl = OP_OR;
`ifdef ALU_CTRL_EXT_OPS_EN
      3'b100:  d.ctrl = OP_XOR;
      3'b001:  d.ctrl = OP_SLL;
      3'b101:  d.ctrl = f7b5 ? OP_SRA : OP_SRL;
      3'b010:  d.ctrl = OP_SLT;
      3'b011:  d.ctrl = OP_SLTU;
`else
      3'b100,
      3'b001,
      3'b101,
      3'b010,
      3'b011:  d = DEC_ILLEGAL;
`endif
      default: d = '{ctrl: OP_ADD, illegal: 1'b0};
    endcase
    return d;
  endfunction

  // Top-level decode. Address and branch classes never look at funct3 or
  // funct7b5, so unknown instruction bits there cannot reach the output.
  function automatic dec_t decode(input logic [1:0] op,
                                  input logic [2:0] f3,
                                  input logic       f7b5);
    dec_t d;
    d = '{ctrl: OP_ADD, illegal: 1'b0};
    case (op)
      ALUOP_ADDR:   d = '{ctrl: OP_ADD, illegal: 1'b0};
      ALUOP_BRANCH: d = '{ctrl: OP_SUB, illegal: 1'b0};
      ALUOP_RTYPE:  d = decode_alu(1'b0, f3, f7b5);
      ALUOP_ITYPE:  d = decode_alu(1'b1, f3, f7b5);
      default:      d = '{ctrl: OP_ADD, illegal: 1'b0};
    endcase
    return d;
  endfunction

  logic [CTRL_W-1:0] alu_ctrl_d;
  logic              illegal_d;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              illegal_q;

  // Combinational decode of the current instruction fields
  always_comb begin
    dec_t dec;
    dec        = decode(bus.alu_op, bus.funct3, bus.funct7b5);
    alu_ctrl_d = dec.ctrl;
    illegal_d  = dec.illegal;
  end

  // Decode -> ALU select stage; reset wins over any pending decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_ctrl_q <= OP_ADD;
      illegal_q  <= 1'b0;
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.alu_ctrl = alu_ctrl_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed bench for alu_control. Expected values are
// hand-computed per build (ALU_CTRL_EXT_OPS_EN defined or not).
module tb_alu_control;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  alu_control_if #(.CTRL_W(4)) bus ();

  alu_control #(.CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  task automatic test_reset();
    drive(2'b10, 3'b100, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (bus.alu_ctrl !== 4'b0010) begin
        err_cnt++;
        $display("FAIL reset[%0d] alu_ctrl got %b want 0010", i, bus.alu_ctrl);
      end
      vec_cnt++;
      if (bus.illegal !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset[%0d] illegal got %b want 0", i, bus.illegal);
      end
    end
  endtask

  task automatic test_addr_branch();
    logic [1:0] ops  [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [3:0] exps [4] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110};
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(ops[i], 3'bxxx, 1'bx);
      else       drive(ops[i], 3'b101, 1'b1);
      tick();
      vec_cnt++;
      if (bus.alu_ctrl !== exps[i]) begin
        err_cnt++;
        $display("FAIL addr_branch[%0d] alu_ctrl got %b want %b", i, bus.alu_ctrl, exps[i]);
      end
      vec_cnt++;
      if (bus.illegal !== 1'b0) begin
        err_cnt++;
        $display("FAIL addr_branch[%0d] illegal got %b want 0", i, bus.illegal);
      end
    end
  endtask

  // Entry: {alu_op[1:0], funct3[2:0], f7b5, alu_ctrl[3:0], illegal}
  task automatic test_rtype_itype();
    logic [10:0] tbl [$];
`ifdef ALU_CTRL_EXT_OPS_EN
    tbl = '{11'b10_000_0_0010_0, 11'b10_000_1_0110_0, 11'b10_111_0_0000_0,
            11'b10_110_1_0001_0, 11'b11_000_1_0010_0, 11'b11_111_0_0000_0,
            11'b11_110_0_0001_0, 11'b11_101_1_0111_0, 11'b11_101_0_0101_0,
            11'b10_100_0_0011_0, 11'b10_001_0_0100_0, 11'b10_010_0_1000_0,
            11'b10_011_1_1001_0, 11'b11_011_0_1001_0, 11'b10_101_1_0111_0};
`else
    tbl = '{11'b10_000_0_0010_0, 11'b10_000_1_0110_0, 11'b10_111_0_0000_0,
            11'b10_110_1_0001_0, 11'b11_000_1_0010_0, 11'b11_111_0_0000_0,
            11'b11_110_0_0001_0, 11'b11_101_1_0010_1, 11'b11_101_0_0010_1,
            11'b10_100_0_0010_1, 11'b10_001_0_0010_1, 11'b10_010_0_0010_1,
            11'b10_011_1_0010_1, 11'b11_011_0_0010_1, 11'b10_101_1_0010_1};
`endif
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i][10:9], tbl[i][8:6], tbl[i][5]);
      tick();
      vec_cnt++;
      if (bus.alu_ctrl !== tbl[i][4:1]) begin
        err_cnt++;
        $display("FAIL decode[%0d] op=%b f3=%b f7=%b alu_ctrl got %b want %b",
                 i, tbl[i][10:9], tbl[i][8:6], tbl[i][5], bus.alu_ctrl, tbl[i][4:1]);
      end
      vec_cnt++;
      if (bus.illegal !== tbl[i][0]) begin
        err_cnt++;
        $display("FAIL decode[%0d] op=%b f3=%b illegal got %b want %b",
                 i, tbl[i][10:9], tbl[i][8:6], bus.illegal, tbl[i][0]);
      end
    end
  endtask

  task automatic test_illegal_recovery();
`ifdef ALU_CTRL_EXT_OPS_EN
    logic [3:0] exp_c [2] = '{4'b0011, 4'b0000};
    logic       exp_i [2] = '{1'b0, 1'b0};
`else
    logic [3:0] exp_c [2] = '{4'b0010, 4'b0000};
    logic       exp_i [2] = '{1'b1, 1'b0};
`endif
    logic [2:0] f3s [2] = '{3'b100, 3'b111};
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(2'b10, f3s[i], 1'b0);
      tick();
      vec_cnt++;
      if (bus.alu_ctrl !== exp_c[i]) begin
        err_cnt++;
        $display("FAIL illegal_recovery[%0d] alu_ctrl got %b want %b", i, bus.alu_ctrl, exp_c[i]);
      end
      vec_cnt++;
      if (bus.illegal !== exp_i[i]) begin
        err_cnt++;
        $display("FAIL illegal_recovery[%0d] illegal got %b want %b", i, bus.illegal, exp_i[i]);
      end
    end
  endtask

  // R-type sweep, index = {funct3, f7b5}; a reset lands mid-sweep.
  task automatic test_back_to_back();
`ifdef ALU_CTRL_EXT_OPS_EN
    logic [3:0]  exp_c [16] = '{4'b0010, 4'b0110, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                4'b0011, 4'b0011, 4'b0101, 4'b0111,
                                4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [15:0] exp_i = 16'h0000;
`else
    logic [3:0]  exp_c [16] = '{4'b0010, 4'b0110, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [15:0] exp_i = 16'h0FFC;
`endif
    logic [3:0] prev_c;
    logic       prev_i;
    logic [3:0] want_c;
    logic       want_i;
    logic [3:0] idx;
    rst_n = 1'b1;
    drive(2'b10, 3'b111, 1'b1);
    tick();
    prev_c = 4'b0000;
    prev_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = 4'(k);
      drive(2'b10, idx[3:1], idx[0]);
      rst_n = (k == 9) ? 1'b0 : 1'b1;
      #1;
      vec_cnt++;
      if (bus.alu_ctrl !== prev_c || bus.illegal !== prev_i) begin
        err_cnt++;
        $display("FAIL b2b_hold[%0d] got %b/%b want %b/%b", k, bus.alu_ctrl, bus.illegal, prev_c, prev_i);
      end
      tick();
      want_c = (k == 9) ? 4'b0010 : exp_c[k];
      want_i = (k == 9) ? 1'b0    : exp_i[k];
      vec_cnt++;
      if (bus.alu_ctrl !== want_c) begin
        err_cnt++;
        $display("FAIL b2b[%0d] alu_ctrl got %b want %b", k, bus.alu_ctrl, want_c);
      end
      vec_cnt++;
      if (bus.illegal !== want_i) begin
        err_cnt++;
        $display("FAIL b2b[%0d] illegal got %b want %b", k, bus.illegal, want_i);
      end
      prev_c = want_c;
      prev_i = want_i;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    drive(2'b00, 3'b000, 1'b0);
    test_reset();
    test_addr_branch();
    test_rtype_itype();
    test_illegal_recovery();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
